// File: rtl/tone_gen.sv
// Multi-channel square/PWM tone generator with glitch-free note changes.
// Define TONE_MIX_EN to add the MIX output (count of channels currently high).
module tone_gen #(
    parameter int CHANNELS = 2,
    parameter int DIV_W    = 20
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [CHANNELS*7-1:0] SEL,
    input  logic [CHANNELS*4-1:0] DUTY,
    input  logic [CHANNELS-1:0]   EN,
    output logic [CHANNELS-1:0]   oCLK
`ifdef TONE_MIX_EN
    ,
    output logic [$clog2(CHANNELS+1)-1:0] MIX
`endif
);

    logic [CHANNELS*7-1:0] sel_r;
    logic [CHANNELS*4-1:0] duty_r;
    logic [CHANNELS-1:0]   en_r;

    function automatic logic [DIV_W-1:0] base_of(input logic [3:0] n);
        case (n)
            4'd0:    base_of = DIV_W'(382225);
            4'd1:    base_of = DIV_W'(360776);
            4'd2:    base_of = DIV_W'(340524);
            4'd3:    base_of = DIV_W'(321412);
            4'd4:    base_of = DIV_W'(303373);
            4'd5:    base_of = DIV_W'(286344);
            4'd6:    base_of = DIV_W'(270270);
            4'd7:    base_of = DIV_W'(255102);
            4'd8:    base_of = DIV_W'(240790);
            4'd9:    base_of = DIV_W'(227273);
            4'd10:   base_of = DIV_W'(214519);
            4'd11:   base_of = DIV_W'(202478);
            default: base_of = '0;
        endcase
    endfunction

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sel_r  <= {CHANNELS{7'h0F}};
            duty_r <= '0;
            en_r   <= '0;
        end else begin
            sel_r  <= SEL;
            duty_r <= DUTY;
            en_r   <= EN;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [6:0]       sel_a;
        logic [3:0]       duty_a;
        logic [DIV_W-1:0] cnt;
        logic [DIV_W-1:0] per;
        logic [DIV_W-1:0] hi;
        logic [DIV_W+3:0] prod;
        logic             tone;
        logic [6:0]       sel_n;
        logic [3:0]       duty_n;
        logic             act_mute;
        logic             nxt_mute;

        assign sel_n    = sel_r[7*i +: 7];
        assign duty_n   = duty_r[4*i +: 4];
        assign act_mute = (sel_a[3:2] == 2'b11);
        assign nxt_mute = (sel_n[3:2] == 2'b11);
        assign oCLK[i]  = tone;

        always_comb begin
            per  = base_of(sel_a[3:0]) >> sel_a[6:4];
            prod = {4'b0, per} * {{DIV_W{1'b0}}, duty_a};
            hi   = prod[DIV_W+3:4];
        end

        // Shadows follow the inputs while idle or muted; otherwise only at wrap.
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                sel_a  <= 7'h0F;
                duty_a <= '0;
                cnt    <= '0;
                tone   <= 1'b0;
            end else if (!en_r[i]) begin
                sel_a  <= sel_n;
                duty_a <= duty_n;
                cnt    <= '0;
                tone   <= 1'b0;
            end else if (act_mute) begin
                cnt  <= '0;
                tone <= 1'b0;
                if (!nxt_mute) begin
                    sel_a  <= sel_n;
                    duty_a <= duty_n;
                end
            end else begin
                tone <= (cnt < hi);
                if (cnt == per - DIV_W'(1)) begin
                    cnt    <= '0;
                    sel_a  <= sel_n;
                    duty_a <= duty_n;
                end else begin
                    cnt <= cnt + DIV_W'(1);
                end
            end
        end
    end

`ifdef TONE_MIX_EN
    localparam int MW = $clog2(CHANNELS+1);

    function automatic logic [MW-1:0] ones(input logic [CHANNELS-1:0] v);
        ones = '0;
        for (int k = 0; k < CHANNELS; k++) ones = ones + MW'(v[k]);
    endfunction

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) MIX <= '0;
        else        MIX <= ones(oCLK);
    end
`endif

endmodule

// File: tb/tb_tone_gen.sv
// Directed bench for tone_gen: periods, duty, glitch-free changes, silence, reset.
// Works with or without TONE_MIX_EN defined.
module tb_tone_gen;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [13:0] SEL;
    logic [7:0]  DUTY;
    logic [1:0]  EN;
    logic [1:0]  oclk;
`ifdef TONE_MIX_EN
    logic [1:0]  mix;
`endif

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    tone_gen #(.CHANNELS(2), .DIV_W(20)) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .SEL  (SEL),
        .DUTY (DUTY),
        .EN   (EN),
        .oCLK (oclk)
`ifdef TONE_MIX_EN
        ,
        .MIX  (mix)
`endif
    );

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic set_ch(input int c, input logic [6:0] s,
                          input logic [3:0] d, input logic e);
        SEL[7*c +: 7] = s;
        DUTY[4*c +: 4] = d;
        EN[c] = e;
    endtask

    // Cycles until the next 0->1 edge on channel c, -1 on timeout.
    task automatic wait_rise(input int c, input int lim, output int n);
        logic prev;
        prev = oclk[c];
        n = -1;
        for (int k = 1; k <= lim; k++) begin
            step();
            if (!prev && oclk[c]) begin
                n = k;
                break;
            end
            prev = oclk[c];
        end
    endtask

    // Starts on a rise sample; measures up to the next rise, optionally
    // changing SEL/DUTY after 'chg' cycles (0 = no change).
    task automatic period(input int c, input int chg, input logic [6:0] s,
                          input logic [3:0] d, input int lim,
                          output int hi, output int per, output int rose);
        logic prev;
        prev = oclk[c];
        hi   = int'(oclk[c]);
        per  = 1;
        rose = 0;
        while (rose == 0 && per < lim) begin
            if (per == chg) begin
                SEL[7*c +: 7] = s;
                DUTY[4*c +: 4] = d;
            end
            step();
            if (oclk[c] && !prev) rose = 1;
            else begin
                per++;
                if (oclk[c]) hi++;
            end
            prev = oclk[c];
        end
    endtask

    int n, hi, per, rose, acc;

    initial begin
        SEL   = {2{7'h0F}};
        DUTY  = '0;
        EN    = '0;
        RST_N = 1'b0;
        repeat (3) step();
        check("rst_o", int'(oclk), 0);
        RST_N = 1'b1;
        acc = 0;
        repeat (20) begin
            step();
            acc += int'(oclk[0]) + int'(oclk[1]);
        end
        check("rst_idle", acc, 0);

        // channel 1 alone: A oct 7, 50%
        set_ch(1, 7'h79, 4'd8, 1'b1);
        wait_rise(1, 4000, n);
        check("ch1_start", int'(n > 0), 1);
        period(1, 0, 7'h79, 4'd8, 5000, hi, per, rose);
        check("ch1_per", per, 1775);
        check("ch1_hi", hi, 887);

        // channel 0: C oct 7, 50%, enable edge
        set_ch(0, 7'h70, 4'd8, 1'b0);
        step();
        step();
        EN[0] = 1'b1;
        wait_rise(0, 10, n);
        check("en_lat", n, 2);
        period(0, 0, 7'h70, 4'd8, 5000, hi, per, rose);
        check("c_per", per, 2986);
        check("c_hi", hi, 1493);

        // mid-period note change finishes the current period first
        period(0, 100, 7'h79, 4'd8, 5000, hi, per, rose);
        check("chg_per", per, 2986);
        check("chg_hi", hi, 1493);
        period(0, 0, 7'h79, 4'd8, 5000, hi, per, rose);
        check("a_per", per, 1775);
        check("a_hi", hi, 887);

        // switch to silence: current period completes, then nothing
        period(0, 100, 7'h7C, 4'd8, 4000, hi, per, rose);
        check("mute_hi", hi, 887);
        check("mute_norise", rose, 0);

        // leaving silence restarts immediately, high first
        SEL[6:0] = 7'h70;
        wait_rise(0, 10, n);
        check("unmute_lat", n, 3);
        period(0, 10, 7'h79, 4'd15, 5000, hi, per, rose);
        check("unmute_per", per, 2986);
        check("unmute_hi", hi, 1493);
        period(0, 0, 7'h79, 4'd15, 5000, hi, per, rose);
        check("d15_per", per, 1775);
        check("d15_hi", hi, 1664);

        // duty 0 after the current period: constant low
        period(0, 10, 7'h79, 4'd0, 4000, hi, per, rose);
        check("d0_hi", hi, 1664);
        check("d0_norise", rose, 0);

        // asynchronous reset mid-tone
        DUTY[3:0] = 4'd8;
        wait_rise(0, 4000, n);
        check("tone_back", int'(n > 0), 1);
        repeat (10) step();
        check("pre_rst_hi", int'(oclk[0]), 1);
        RST_N = 1'b0;
        #1;
        check("rst_async", int'(oclk), 0);
        EN = '0;
        step();
        step();
        RST_N = 1'b1;
        acc = 0;
        repeat (50) begin
            step();
            acc += int'(oclk[0]) + int'(oclk[1]);
        end
        check("post_rst_idle", acc, 0);
        EN[0] = 1'b1;
        wait_rise(0, 10, n);
        check("post_rst_lat", n, 2);
        period(0, 0, 7'h79, 4'd8, 5000, hi, per, rose);
        check("post_rst_per", per, 1775);
        check("post_rst_hi", hi, 887);

`ifdef TONE_MIX_EN
        EN = '0;
        set_ch(0, 7'h79, 4'd15, 1'b0);
        set_ch(1, 7'h79, 4'd15, 1'b0);
        repeat (4) step();
        EN = 2'b11;
        begin
            int prevc;
            int seen2;
            prevc = int'(oclk[0]) + int'(oclk[1]);
            seen2 = 0;
            repeat (2000) begin
                step();
                check("mix", int'(mix), prevc);
                if (mix == 2'd2) seen2 = 1;
                prevc = int'(oclk[0]) + int'(oclk[1]);
            end
            check("mix_two", seen2, 1);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
